// File: rtl/onehot_seq_if.sv
// Command/status bundle for onehot_seq; mask_i exists only with ONEHOT_SEQ_MASK_EN.
// master drives commands, slave (the sequencer) returns the registered position.
interface onehot_seq_if #(
  parameter int P_BIT     = 5,
  parameter int P_OUT_BIT = 32
);
  logic                 clr_i;
  logic                 load_i;
  logic [P_BIT-1:0]     idx_i;
  logic                 step_i;
  logic                 dir_i;
`ifdef ONEHOT_SEQ_MASK_EN
  logic [P_OUT_BIT-1:0] mask_i;
`endif
  logic [P_OUT_BIT-1:0] sig_o;
  logic [P_BIT-1:0]     idx_o;
  logic                 vld_o;
  logic                 wrap_o;
  logic                 err_o;

  modport master (
`ifdef ONEHOT_SEQ_MASK_EN
    output mask_i,
`endif
    output clr_i, output load_i, output idx_i, output step_i, output dir_i,
    input  sig_o, input  idx_o,  input  vld_o, input  wrap_o, input  err_o
  );

  modport slave (
`ifdef ONEHOT_SEQ_MASK_EN
    input  mask_i,
`endif
    input  clr_i, input  load_i, input  idx_i, input  step_i, input  dir_i,
    output sig_o, output idx_o,  output vld_o, output wrap_o, output err_o
  );
endinterface

// File: rtl/onehot_seq.sv
// Registered one-hot position sequencer (load/step/clear); ONEHOT_SEQ_MASK_EN adds a skip mask.
// Latency: 1 cycle from command to every output, all outputs registered.
// Backpressure: none, a command is accepted every cycle (clr > load > step).
module onehot_seq #(
  parameter int P_BIT     = 5,
  parameter int P_OUT_BIT = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  onehot_seq_if.slave  bus
);

  localparam int               LP_SPAN = 2 ** P_BIT;
  localparam logic [P_BIT:0]   LP_N    = (P_BIT + 1)'(P_OUT_BIT);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [P_BIT-1:0]       idx_q, idx_d;
  logic [P_OUT_BIT-1:0]   sig_q, sig_d;
  logic                   wrap_q, wrap_d;
  logic                   err_q, err_d;

  logic [P_OUT_BIT-1:0]   mask_eff;
  logic [LP_SPAN-1:0]     mask_ext;
  logic                   load_ok;
  logic                   step_found;
  logic                   step_wrap;
  logic [P_BIT-1:0]       step_idx;
  logic [P_BIT:0]         cand;
  logic                   crossed;

`ifdef ONEHOT_SEQ_MASK_EN
  assign mask_eff = bus.mask_i;
`else
  assign mask_eff = '1;
`endif

  // Zero-extend to the full index space so any idx value selects a defined bit.
  always_comb begin
    mask_ext                  = '0;
    mask_ext[P_OUT_BIT-1:0]   = mask_eff;
  end

  // Range check is done one bit wider so P_OUT_BIT == 2**P_BIT compares exactly.
  assign load_ok = ({1'b0, bus.idx_i} < LP_N) && mask_ext[bus.idx_i];

  // Circular search for the nearest allowed position in the step direction.
  always_comb begin
    step_found = 1'b0;
    step_wrap  = 1'b0;
    step_idx   = idx_q;
    cand       = '0;
    crossed    = 1'b0;
    for (int k = 1; k < P_OUT_BIT; k++) begin
      if (!step_found) begin
        if (!bus.dir_i) begin
          cand    = {1'b0, idx_q} + (P_BIT + 1)'(k);
          crossed = (cand >= LP_N);
          if (crossed) begin
            cand = cand - LP_N;
          end
        end else begin
          crossed = ((P_BIT + 1)'(k) > {1'b0, idx_q});
          cand    = crossed ? ({1'b0, idx_q} + LP_N - (P_BIT + 1)'(k))
                            : ({1'b0, idx_q} - (P_BIT + 1)'(k));
        end
        if (mask_ext[cand[P_BIT-1:0]]) begin
          step_found = 1'b1;
          step_wrap  = crossed;
          step_idx   = cand[P_BIT-1:0];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.clr_i) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (bus.load_i) begin
      if (load_ok) begin
        state_d = ST_ACTIVE;
        idx_d   = bus.idx_i;
      end else begin
        state_d = ST_IDLE;
        idx_d   = '0;
        err_d   = 1'b1;
      end
    end else if (bus.step_i && (state_q == ST_ACTIVE)) begin
      if (step_found) begin
        idx_d  = step_idx;
        wrap_d = step_wrap;
      end else if (!mask_ext[idx_q]) begin
        // Nothing else allowed and the current slot is masked too: mask is empty.
        state_d = ST_IDLE;
        idx_d   = '0;
        err_d   = 1'b1;
      end
    end
  end

  always_comb begin
    sig_d = '0;
    for (int i = 0; i < P_OUT_BIT; i++) begin
      sig_d[i] = (state_d == ST_ACTIVE) && (idx_d == P_BIT'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sig_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sig_q   <= sig_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.sig_o  = sig_q;
  assign bus.idx_o  = idx_q;
  assign bus.vld_o  = (state_q == ST_ACTIVE);
  assign bus.wrap_o = wrap_q;
  assign bus.err_o  = err_q;

endmodule
